// File: rtl/instr_fetch_seq.sv
// Instruction fetch/issue sequencer: PC, 1-cycle synchronous imem read, valid/ready issue, local branch redirect, HALT stop.
// One instruction per FETCH/WAIT/ISSUE round; ISSUE holds every output frozen while issue_ready is low.
module instr_fetch_seq #(
  parameter int                   INSTR_W   = 8,
  parameter int                   PC_W      = 6,
  parameter int                   OFF_W     = 4,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   HALT_WORD = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [1:0]         instr_bit,
  output logic [PC_W-1:0]    pc_out,
  output logic               branch_taken,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [INSTR_W-1:0]   instr_q;
  logic [PC_W-1:0]      pc_out_q;
  logic                 rd_en_q;
  logic                 valid_q;
  logic                 br_q;
  logic                 halted_q;

  logic signed [OFF_W-1:0] off_s;
  logic [PC_W-1:0]         pc_next_d;
  logic                    is_branch;

  // The offset is signed; the size cast sign-extends it and the add wraps modulo 2^PC_W.
  assign off_s     = instr_q[OFF_W-1:0];
  assign is_branch = instr_q[INSTR_W-1];
  assign pc_next_d = is_branch ? (pc_q + PC_W'(off_s)) : (pc_q + PC_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= RESET_PC;
      rd_en_q  <= 1'b0;
      valid_q  <= 1'b0;
      br_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      br_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q    <= RESET_PC;
            rd_en_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          rd_en_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rdata == HALT_WORD) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            instr_q  <= imem_rdata;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            pc_q    <= pc_next_d;
            br_q    <= is_branch;
            valid_q <= 1'b0;
            rd_en_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_HALT: begin
          if (start) begin
            halted_q <= 1'b0;
            pc_q     <= RESET_PC;
            rd_en_q  <= 1'b1;
            state_q  <= S_FETCH;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          rd_en_q  <= 1'b0;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_rd_en   = rd_en_q;
  assign imem_addr    = pc_q;
  assign issue_valid  = valid_q;
  assign instr_out    = instr_q;
  assign instr_bit    = instr_q[INSTR_W-1 -: 2];
  assign pc_out       = pc_out_q;
  assign branch_taken = br_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with a synchronous 64x8 memory model.
module tb_instr_fetch_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       imem_rd_en;
  logic [5:0] imem_addr;
  logic [7:0] imem_rdata = 8'h00;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic [7:0] instr_out;
  logic [1:0] instr_bit;
  logic [5:0] pc_out;
  logic       branch_taken;
  logic       halted;

  logic [7:0] mem [64];
  int errors = 0;
  int checks = 0;
  int reads = 0;
  int hs = 0;
  int brs = 0;
  int snap;

  instr_fetch_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .instr_out(instr_out), .instr_bit(instr_bit), .pc_out(pc_out),
    .branch_taken(branch_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) begin
      imem_rdata <= mem[imem_addr];
      reads++;
    end
    if (reset && issue_valid && issue_ready) hs++;
    if (branch_taken) brs++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Start and advance to the first ISSUE cycle (start sampled on the first of three edges).
  task automatic start_to_issue();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(); tick();
    if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", issue_valid); end checks++;
    if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b want 0", imem_rd_en); end checks++;
    if (instr_out !== 8'h00) begin errors++; $display("FAIL rst_instr got %h want 00", instr_out); end checks++;
    if (pc_out !== 6'd0) begin errors++; $display("FAIL rst_pc_out got %0d want 0", pc_out); end checks++;
    reset = 1'b1;
    clear_mem(); mem[0] = 8'h41;
    issue_ready = 1'b0;
    start_to_issue();
    if (issue_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_issue got %b want 1", issue_valid); end checks++;
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", issue_valid); end checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL rst_mid_halted got %b want 0", halted); end checks++;
    if (imem_addr !== 6'd0) begin errors++; $display("FAIL rst_mid_addr got %0d want 0", imem_addr); end checks++;
    if (instr_out !== 8'h00) begin errors++; $display("FAIL rst_mid_instr got %h want 00", instr_out); end checks++;
    snap = reads;
    repeat (4) tick();
    if (reads !== snap) begin errors++; $display("FAIL rst_no_reads got %0d want %0d", reads, snap); end checks++;
    if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %b want 0", issue_valid); end checks++;
  endtask

  task automatic test_straight();
    do_reset(); clear_mem();
    mem[0] = 8'h41; mem[1] = 8'h05; mem[2] = 8'hFF;
    issue_ready = 1'b1;
    snap = hs;
    start = 1'b1; tick(); start = 1'b0;
    if (imem_rd_en !== 1'b1 || imem_addr !== 6'd0) begin errors++; $display("FAIL st_fetch0 got rd=%b addr=%0d want rd=1 addr=0", imem_rd_en, imem_addr); end checks++;
    tick();
    if (imem_rd_en !== 1'b0 || issue_valid !== 1'b0) begin errors++; $display("FAIL st_wait0 got rd=%b v=%b want 0 0", imem_rd_en, issue_valid); end checks++;
    tick();
    if (issue_valid !== 1'b1) begin errors++; $display("FAIL st_latency got v=%b want 1", issue_valid); end checks++;
    if (instr_out !== 8'h41 || instr_bit !== 2'b01 || pc_out !== 6'd0) begin errors++; $display("FAIL st_issue0 got %h/%b/%0d want 41/01/0", instr_out, instr_bit, pc_out); end checks++;
    tick();
    if (issue_valid !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 6'd1) begin errors++; $display("FAIL st_fetch1 got v=%b rd=%b addr=%0d want 0 1 1", issue_valid, imem_rd_en, imem_addr); end checks++;
    if (branch_taken !== 1'b0) begin errors++; $display("FAIL st_no_branch got %b want 0", branch_taken); end checks++;
    tick(); tick();
    if (issue_valid !== 1'b1 || instr_out !== 8'h05 || instr_bit !== 2'b00 || pc_out !== 6'd1) begin errors++; $display("FAIL st_issue1 got v=%b %h/%b/%0d want 1 05/00/1", issue_valid, instr_out, instr_bit, pc_out); end checks++;
    tick();
    if (imem_addr !== 6'd2 || imem_rd_en !== 1'b1) begin errors++; $display("FAIL st_fetch2 got addr=%0d rd=%b want 2 1", imem_addr, imem_rd_en); end checks++;
    tick(); tick();
    if (halted !== 1'b1 || issue_valid !== 1'b0) begin errors++; $display("FAIL st_halt got h=%b v=%b want 1 0", halted, issue_valid); end checks++;
    tick(); tick();
    if (hs - snap !== 2) begin errors++; $display("FAIL st_issue_count got %0d want 2", hs - snap); end checks++;
    if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL st_halt_rd got %b want 0", imem_rd_en); end checks++;
  endtask

  task automatic test_fwd_branch();
    do_reset(); clear_mem();
    mem[0] = 8'h83; mem[1] = 8'h05;
    issue_ready = 1'b1;
    snap = brs;
    start_to_issue();
    if (instr_bit !== 2'b10) begin errors++; $display("FAIL fb_class got %b want 10", instr_bit); end checks++;
    tick();
    if (branch_taken !== 1'b1 || imem_addr !== 6'd3 || imem_rd_en !== 1'b1) begin errors++; $display("FAIL fb_redirect got bt=%b addr=%0d rd=%b want 1 3 1", branch_taken, imem_addr, imem_rd_en); end checks++;
    tick();
    if (branch_taken !== 1'b0) begin errors++; $display("FAIL fb_pulse got %b want 0", branch_taken); end checks++;
    tick();
    if (halted !== 1'b1) begin errors++; $display("FAIL fb_halt got %b want 1", halted); end checks++;
    if (brs - snap !== 1) begin errors++; $display("FAIL fb_pulse_count got %0d want 1", brs - snap); end checks++;
  endtask

  task automatic test_back_branch();
    do_reset(); clear_mem();
    mem[0] = 8'h8F; mem[63] = 8'hFF;
    issue_ready = 1'b1;
    start_to_issue();
    tick();
    if (imem_addr !== 6'd63 || branch_taken !== 1'b1) begin errors++; $display("FAIL bb_wrap got addr=%0d bt=%b want 63 1", imem_addr, branch_taken); end checks++;
    tick(); tick();
    if (halted !== 1'b1) begin errors++; $display("FAIL bb_halt got %b want 1", halted); end checks++;
  endtask

  task automatic test_stall();
    do_reset(); clear_mem();
    mem[0] = 8'h41;
    issue_ready = 1'b0;
    start_to_issue();
    snap = reads;
    for (int i = 0; i < 5; i++) begin
      if (issue_valid !== 1'b1 || instr_out !== 8'h41 || pc_out !== 6'd0 || imem_rd_en !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b %h pc=%0d rd=%b want 1 41 0 0", i, issue_valid, instr_out, pc_out, imem_rd_en);
      end
      checks++;
      tick();
    end
    if (reads !== snap) begin errors++; $display("FAIL stall_reads got %0d want %0d", reads, snap); end checks++;
    snap = hs;
    issue_ready = 1'b1; tick(); issue_ready = 1'b0;
    if (hs - snap !== 1) begin errors++; $display("FAIL stall_one_hs got %0d want 1", hs - snap); end checks++;
    if (imem_addr !== 6'd1 || imem_rd_en !== 1'b1 || issue_valid !== 1'b0) begin errors++; $display("FAIL stall_next got addr=%0d rd=%b v=%b want 1 1 0", imem_addr, imem_rd_en, issue_valid); end checks++;
    tick(); tick();
    if (halted !== 1'b1) begin errors++; $display("FAIL stall_halt got %b want 1", halted); end checks++;
  endtask

  task automatic test_restart();
    mem[0] = 8'h05; mem[1] = 8'hFF;
    issue_ready = 1'b0;
    start = 1'b1; tick();
    if (halted !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 6'd0) begin errors++; $display("FAIL rs_fetch got h=%b rd=%b addr=%0d want 0 1 0", halted, imem_rd_en, imem_addr); end checks++;
    tick();
    if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL rs_start_in_fetch got rd=%b want 0", imem_rd_en); end checks++;
    tick(); start = 1'b0;
    if (issue_valid !== 1'b1 || instr_out !== 8'h05 || pc_out !== 6'd0) begin errors++; $display("FAIL rs_issue got v=%b %h pc=%0d want 1 05 0", issue_valid, instr_out, pc_out); end checks++;
    issue_ready = 1'b1; tick();
    if (imem_addr !== 6'd1) begin errors++; $display("FAIL rs_next got %0d want 1", imem_addr); end checks++;
    tick(); tick();
    if (halted !== 1'b1) begin errors++; $display("FAIL rs_halt got %b want 1", halted); end checks++;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_straight();
    test_fwd_branch();
    test_back_branch();
    test_stall();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction fetch/issue sequencer: the producer end of the 2-bit instruction-class field that the control unit decodes.
- Holds the PC and reads words from a synchronous instruction memory with 1-cycle read latency.
- Issues each word with a valid/ready handshake; exposes its class bits {branch, alu_type}.
- Resolves branches locally by PC-relative redirect; stops on a HALT word.

Parameters:
- INSTR_W, 8, instruction width; class field is bits [INSTR_W-1:INSTR_W-2] (bit INSTR_W-1 = branch, bit INSTR_W-2 = R-type/I-type).
- PC_W, 6, program counter / memory address width.
- OFF_W, 4, branch offset width (signed, bits [OFF_W-1:0]); must be <= INSTR_W-2 and <= PC_W.
- RESET_PC, 0, PC value after reset and on (re)start.
- HALT_WORD, all ones (INSTR_W bits), stop encoding.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  begin fetching from RESET_PC; honoured in IDLE and HALT only.
- imem_rd_en  out  1  memory read strobe.
- imem_addr  out  PC_W  memory address (= current PC).
- imem_rdata  in  INSTR_W  memory data, valid the cycle after imem_rd_en.
- issue_valid  out  1  instr_out holds a valid instruction.
- issue_ready  in  1  consumer accepts instruction.
- instr_out  out  INSTR_W  issued instruction word.
- instr_bit  out  2  = instr_out[INSTR_W-1:INSTR_W-2], feeds control unit.
- pc_out  out  PC_W  PC of instr_out.
- branch_taken  out  1  one-cycle pulse when a branch is accepted.
- halted  out  1  sequencer stopped on HALT_WORD.

Behaviour:
- Reset (reset==0 at clk edge, overrides everything, including mid-fetch or mid-issue):
  - state = IDLE, PC = RESET_PC.
  - imem_rd_en, issue_valid, branch_taken, halted = 0; instr_out = 0; pc_out = RESET_PC.
- imem_addr is always PC.
- States:
  - IDLE: all strobes 0. start=1 -> PC = RESET_PC, go to FETCH.
  - FETCH: imem_rd_en = 1 for exactly this cycle. Go to WAIT.
  - WAIT: imem_rd_en = 0. At the clock edge, capture imem_rdata.
    - Captured word == HALT_WORD -> go to HALT (not issued).
    - Otherwise load instr_out and pc_out = PC, go to ISSUE.
  - ISSUE: issue_valid = 1. instr_out, pc_out and instr_bit are held stable until the handshake (issue_valid and issue_ready both 1 at a clk edge).
    - On handshake, if branch bit = 1: PC = PC + sign_extend(instr_out[OFF_W-1:0]) modulo 2^PC_W; branch_taken = 1 next cycle.
    - On handshake, if branch bit = 0: PC = PC + 1 modulo 2^PC_W.
    - Then go to FETCH. issue_valid drops the cycle after the handshake.
  - HALT: halted = 1, no memory reads. start=1 -> halted = 0, PC = RESET_PC, go to FETCH.
- start is ignored in FETCH, WAIT and ISSUE.
- Throughput: at most one instruction per 3 cycles (FETCH, WAIT, ISSUE). Latency from start sampled to first issue_valid is 3 cycles.
- Wrap-around:
  - PC = 2^PC_W - 1 plus 1 gives 0.
  - A branch target computed below 0 or above the top address wraps modulo 2^PC_W.
- Branch offset 0 re-fetches the same address indefinitely; this is legal.
- issue_ready held 0 indefinitely stalls in ISSUE with all outputs frozen; no memory reads occur.
- issue_ready asserted outside ISSUE has no effect.

Test Plan:
- Reset with reset=0 for 2 cycles during ISSUE -> next cycle issue_valid=0, halted=0, imem_addr=0, state IDLE; no reads until start.
- Straight-line code: mem[0..2]=0x41,0x05,0xFF, ready always 1, start=1 -> issues 0x41 (instr_bit=01, pc_out=0) then 0x05 (instr_bit=00, pc_out=1); first issue_valid 3 cycles after start; read of addr 2 returns HALT -> halted=1, no third issue.
- Forward branch: mem[0]=0x83 (branch, offset +3), mem[3]=0xFF -> branch_taken pulses once; next imem_addr=3; then halted=1.
- Backward branch with wrap: mem[0]=0x8F (offset -1) -> next fetch address 63; mem[63]=0xFF -> halted.
- Stall: ready=0 for 5 cycles in ISSUE -> instr_out, pc_out, issue_valid stable; imem_rd_en=0 throughout. Ready=1 -> exactly one handshake, next fetch at PC+1.
- Restart from HALT: start=1 while halted -> halted=0 next cycle, imem_rd_en=1 with imem_addr=RESET_PC; start pulses during FETCH/WAIT are ignored.
